// File: rtl/mult_pipe.sv
// Unsigned 64x64 multiply, retiring 64/STAGES multiplier bits per stage; MULT_UMULH_EN adds func (1 = high half).
// Latency: STAGES cycles from acceptance to fu_done; one op per cycle.
// Backpressure: fub_busy with a valid last stage freezes every stage and drops mult_ready.
module mult_pipe #(
   parameter int STAGES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid_in,
   input  logic [63:0] opa,
   input  logic [63:0] opb,
   input  logic [5:0]  tagDest_in,
   input  logic [3:0]  bmask_in,
`ifdef MULT_UMULH_EN
   input  logic        func,
`endif
   input  logic        br_done,
   input  logic        br_pred_wrong,
   input  logic [1:0]  br_bs_ptr,
   input  logic        fub_busy,
   output logic        mult_ready,
   output logic        fu_done,
   output logic [63:0] fu_result,
   output logic [5:0]  fu_tagDest,
   output logic [3:0]  fu_bmask
);

   localparam int BITS = 64 / STAGES;
`ifdef MULT_UMULH_EN
   localparam int ACC_W = 128;
`else
   localparam int ACC_W = 64;
`endif

   if (STAGES < 2 || (64 % STAGES) != 0) begin : g_bad_stages
      $error("mult_pipe: STAGES must divide 64 and be at least 2");
   end

   typedef struct packed {
      logic             vld;
      logic [5:0]       tag;
      logic [3:0]       bmask;
`ifdef MULT_UMULH_EN
      logic             func;
`endif
      logic [ACC_W-1:0] prod;
      logic [63:0]      mplier;
      logic [ACC_W-1:0] mcand;
   } stage_t;

   stage_t stg [STAGES];
   stage_t src [STAGES];
   stage_t nxt [STAGES];

   logic advance;
   logic br_kill;
   logic br_clear;

   assign advance    = !(fub_busy && stg[STAGES-1].vld);
   assign mult_ready = advance;
   assign br_kill    = br_done && br_pred_wrong;
   assign br_clear   = br_done && !br_pred_wrong;

   // One radix-2^BITS step: add this chunk's partial product, then shift both operands.
   function automatic stage_t step(input stage_t s);
      stage_t r;
      r        = s;
      r.prod   = s.prod + s.mcand * ACC_W'(s.mplier[BITS-1:0]);
      r.mplier = s.mplier >> BITS;
      r.mcand  = s.mcand << BITS;
      return r;
   endfunction

   function automatic stage_t resolve(input stage_t s);
      stage_t r;
      r = s;
      if (br_kill && s.bmask[br_bs_ptr])
         r.vld = 1'b0;
      if (br_clear)
         r.bmask[br_bs_ptr] = 1'b0;
      return r;
   endfunction

   always_comb begin
      src[0]        = '0;
      src[0].vld    = valid_in;
      src[0].tag    = tagDest_in;
      src[0].bmask  = bmask_in;
`ifdef MULT_UMULH_EN
      src[0].func   = func;
`endif
      src[0].mplier = opb;
      src[0].mcand  = ACC_W'(opa);
      for (int i = 1; i < STAGES; i++)
         src[i] = stg[i-1];
      // Branch resolution also hits held stages, so it is applied after the advance mux.
      for (int i = 0; i < STAGES; i++)
         nxt[i] = resolve(advance ? step(src[i]) : stg[i]);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < STAGES; i++)
            stg[i] <= '0;
      end else begin
         for (int i = 0; i < STAGES; i++)
            stg[i] <= nxt[i];
      end
   end

   assign fu_done    = stg[STAGES-1].vld;
   assign fu_tagDest = stg[STAGES-1].tag;
   assign fu_bmask   = stg[STAGES-1].bmask;
`ifdef MULT_UMULH_EN
   assign fu_result  = stg[STAGES-1].func ? stg[STAGES-1].prod[127:64] : stg[STAGES-1].prod[63:0];
`else
   assign fu_result  = stg[STAGES-1].prod[63:0];
`endif

endmodule

// File: tb/tb_mult_pipe.sv
// Bench for mult_pipe: vector table, directed stall/branch/reset sequences and a random stream,
// all checked against a queue of expected results.
module tb_mult_pipe;

   localparam int STAGES = 4;
`ifdef MULT_UMULH_EN
   localparam bit HAS_UMULH = 1'b1;
`else
   localparam bit HAS_UMULH = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_in;
   logic [63:0] opa, opb;
   logic [5:0]  tagDest_in;
   logic [3:0]  bmask_in;
   logic        func;
   logic        br_done, br_pred_wrong;
   logic [1:0]  br_bs_ptr;
   logic        fub_busy;
   logic        mult_ready, fu_done;
   logic [63:0] fu_result;
   logic [5:0]  fu_tagDest;
   logic [3:0]  fu_bmask;

   mult_pipe #(.STAGES(STAGES)) dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .opa(opa), .opb(opb),
      .tagDest_in(tagDest_in), .bmask_in(bmask_in),
`ifdef MULT_UMULH_EN
      .func(func),
`endif
      .br_done(br_done), .br_pred_wrong(br_pred_wrong), .br_bs_ptr(br_bs_ptr),
      .fub_busy(fub_busy), .mult_ready(mult_ready), .fu_done(fu_done),
      .fu_result(fu_result), .fu_tagDest(fu_tagDest), .fu_bmask(fu_bmask)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic [5:0]  tag;
      logic [3:0]  bm;
      logic        fn;
      logic [63:0] exp;
   } vec_t;

   typedef struct {
      logic [5:0]  tag;
      logic [3:0]  bm;
      logic [63:0] res;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_res;
   logic [3:0]  last_bm;
   vec_t        tab [13];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b, input logic fn);
      logic [127:0] p;
      p = {64'd0, a} * {64'd0, b};
      return fn ? p[127:64] : p[63:0];
   endfunction

   // Scoreboard: pop on consumption, then apply branch resolution, then push the accepted op.
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         q.delete();
      end else begin
         if (fu_done && !fub_busy) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got tag %0d result %h, expected no result", fu_tagDest, fu_result);
            end else begin
               e = q.pop_front();
               chk("result", fu_result, e.res);
               chk("tag", 64'(fu_tagDest), 64'(e.tag));
               chk("bmask", 64'(fu_bmask), 64'(e.bm));
               last_bm = fu_bmask;
            end
         end
         if (br_done) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
               if (q[i].bm[br_bs_ptr]) begin
                  if (br_pred_wrong) q.delete(i);
                  else begin
                     e = q[i];
                     e.bm[br_bs_ptr] = 1'b0;
                     q[i] = e;
                  end
               end
            end
         end
         if (valid_in && mult_ready && !(br_done && br_pred_wrong && bmask_in[br_bs_ptr])) begin
            e.tag = tagDest_in;
            e.bm  = bmask_in;
            if (br_done && !br_pred_wrong) e.bm[br_bs_ptr] = 1'b0;
            e.res = exp_res;
            q.push_back(e);
         end
      end
   end

   task automatic next();
      @(posedge clk);
      #1;
      valid_in      = 1'b0;
      br_done       = 1'b0;
      br_pred_wrong = 1'b0;
   endtask

   task automatic set_op(input logic [63:0] a, input logic [63:0] b, input logic [5:0] tag,
                         input logic [3:0] bm, input logic fn, input logic [63:0] ex);
      valid_in   = 1'b1;
      opa        = a;
      opb        = b;
      tagDest_in = tag;
      bmask_in   = bm;
      func       = fn;
      exp_res    = ex;
   endtask

   task automatic op(input logic [63:0] a, input logic [63:0] b, input logic [5:0] tag, input logic [3:0] bm);
      next();
      set_op(a, b, tag, bm, 1'b0, model(a, b, 1'b0));
   endtask

   task automatic br(input logic [1:0] ptr, input logic wrong);
      next();
      br_done       = 1'b1;
      br_pred_wrong = wrong;
      br_bs_ptr     = ptr;
   endtask

   task automatic drain(input string name);
      for (int k = 0; k < 200 && q.size() != 0; k++) next();
      chk({name, "_drained"}, 64'(q.size()), 64'd0);
      repeat (STAGES + 2) next();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      tab[0]  = '{64'd3, 64'd5, 6'd7, 4'b0000, 1'b0, 64'd15};
      tab[1]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 6'd1, 4'b0000, 1'b0, 64'd1};
      tab[2]  = '{64'd0, 64'h1234, 6'd2, 4'b0101, 1'b0, 64'd0};
      tab[3]  = '{64'd1, 64'hCAFE_BABE_DEAD_BEEF, 6'd3, 4'b1000, 1'b0, 64'hCAFE_BABE_DEAD_BEEF};
      tab[4]  = '{64'h1_0000_0000, 64'h1_0000_0000, 6'd4, 4'b0000, 1'b0, 64'd0};
      tab[5]  = '{64'h1_0000_0001, 64'h1_0000_0001, 6'd5, 4'b0011, 1'b0, 64'h0000_0002_0000_0001};
      tab[6]  = '{64'h8000_0000_0000_0000, 64'd2, 6'd6, 4'b0000, 1'b0, 64'd0};
      tab[7]  = '{64'h1_2345_6789, 64'h1000, 6'd63, 4'b1111, 1'b0, 64'h0000_1234_5678_9000};
      tab[8]  = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 6'd8, 4'b0000, 1'b0, 64'hFFFF_FFFE_0000_0001};
      tab[9]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 6'd9, 4'b0000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE};
      tab[10] = '{64'h1_0000_0000, 64'h1_0000_0000, 6'd10, 4'b0000, 1'b1, 64'd1};
      tab[11] = '{64'h8000_0000_0000_0000, 64'd2, 6'd11, 4'b0000, 1'b1, 64'd1};
      tab[12] = '{64'd3, 64'd5, 6'd12, 4'b0000, 1'b1, 64'd0};

      reset = 1'b0; valid_in = 1'b0; opa = '0; opb = '0; tagDest_in = '0; bmask_in = '0;
      func = 1'b0; br_done = 1'b0; br_pred_wrong = 1'b0; br_bs_ptr = '0; fub_busy = 1'b0;
      exp_res = '0; last_bm = '1;
      #2;
      chk("reset_fu_done", 64'(fu_done), 64'd0);
      chk("reset_fu_result", fu_result, 64'd0);
      chk("reset_fu_tag", 64'(fu_tagDest), 64'd0);
      chk("reset_fu_bmask", 64'(fu_bmask), 64'd0);
      chk("reset_mult_ready", 64'(mult_ready), 64'd1);
      repeat (2) next();
      reset = 1'b1;
      next();

      // Exact latency: 3*5 tag 7 appears in the STAGES-th cycle after acceptance.
      next();
      set_op(64'd3, 64'd5, 6'd7, 4'b0000, 1'b0, 64'd15);
      @(posedge clk);
      #1 valid_in = 1'b0;
      for (int k = 1; k <= STAGES; k++) begin
         @(negedge clk);
         chk("latency_fu_done", 64'(fu_done), (k == STAGES) ? 64'd1 : 64'd0);
      end
      chk("latency_result", fu_result, 64'd15);
      chk("latency_tag", 64'(fu_tagDest), 64'd7);
      drain("latency");

      // Vector table, issued back to back.
      for (int i = 0; i < 13; i++) begin
         if (tab[i].fn && !HAS_UMULH) continue;
         next();
         set_op(tab[i].a, tab[i].b, tab[i].tag, tab[i].bm, tab[i].fn, tab[i].exp);
      end
      drain("table");

      // Four back-to-back ops then a three-cycle stall; stalled valid_in must be ignored.
      for (int i = 0; i < 4; i++) op(64'(i + 2), 64'd7, 6'(10 + i), 4'b0000);
      next();
      fub_busy = 1'b1;
      @(negedge clk);
      chk("stall_ready", 64'(mult_ready), 64'd0);
      chk("stall_done", 64'(fu_done), 64'd1);
      chk("stall_hold_result", fu_result, 64'd14);
      chk("stall_hold_tag", 64'(fu_tagDest), 64'd10);
      repeat (2) begin
         next();
         set_op(64'd99, 64'd99, 6'd63, 4'b0000, 1'b0, 64'd9801);
         @(negedge clk);
         chk("stall_ready", 64'(mult_ready), 64'd0);
         chk("stall_hold_result", fu_result, 64'd14);
      end
      next();
      fub_busy = 1'b0;
      drain("stall");

      // Mispredict on slot 0 kills both ops carrying bit 0.
      op(64'd11, 64'd3, 6'd21, 4'b0001);
      op(64'd12, 64'd3, 6'd22, 4'b0010);
      op(64'd13, 64'd3, 6'd23, 4'b0001);
      br(2'd0, 1'b1);
      drain("squash");
      chk("squash_survivor_bmask", 64'(last_bm), 64'd2);

      // Correct prediction on slot 2 clears that bit in flight.
      op(64'd6, 64'd7, 6'd30, 4'b0100);
      br(2'd2, 1'b0);
      drain("resolve");
      chk("resolve_fu_bmask", 64'(last_bm), 64'd0);

      // Squash of the stalled last stage frees the slot.
      op(64'd5, 64'd5, 6'd40, 4'b1000);
      repeat (STAGES - 1) next();
      next();
      fub_busy = 1'b1;
      br_done = 1'b1; br_pred_wrong = 1'b1; br_bs_ptr = 2'd3;
      @(negedge clk);
      chk("squash_stall_ready", 64'(mult_ready), 64'd0);
      next();
      @(negedge clk);
      chk("squash_stall_freed", 64'(mult_ready), 64'd1);
      chk("squash_stall_done", 64'(fu_done), 64'd0);
      fub_busy = 1'b0;
      drain("squash_stall");

      // Reset mid-flight discards everything.
      op(64'd2, 64'd2, 6'd50, 4'b0000);
      op(64'd3, 64'd3, 6'd51, 4'b0000);
      op(64'd4, 64'd4, 6'd52, 4'b0000);
      next();
      reset = 1'b0;
      #1;
      chk("midreset_fu_done", 64'(fu_done), 64'd0);
      chk("midreset_fu_result", fu_result, 64'd0);
      chk("midreset_ready", 64'(mult_ready), 64'd1);
      next();
      reset = 1'b1;
      for (int k = 0; k < 2 * STAGES; k++) begin
         next();
         @(negedge clk);
         chk("postreset_no_done", 64'(fu_done), 64'd0);
      end
      op(64'd9, 64'd9, 6'd53, 4'b0000);
      drain("postreset");

      // Random stream with random backpressure and branch resolution.
      for (int i = 0; i < 300; i++) begin
         logic [63:0] a, b;
         logic        fn;
         next();
         fub_busy = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 3) != 0) begin
            a  = {$urandom, $urandom};
            b  = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : 64'($urandom_range(0, 1000));
            fn = HAS_UMULH ? 1'($urandom_range(0, 1)) : 1'b0;
            set_op(a, b, 6'($urandom_range(0, 63)), 4'($urandom_range(0, 15)), fn, model(a, b, fn));
         end
         if ($urandom_range(0, 7) == 0) begin
            br_done       = 1'b1;
            br_pred_wrong = 1'($urandom_range(0, 1));
            br_bs_ptr     = 2'($urandom_range(0, 3));
         end
      end
      next();
      fub_busy = 1'b0;
      drain("random");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
